// File: rtl/sel_arb_pkg.sv
// Shared types and encodings for the select-datapath burst arbiter.
package sel_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } sel_arb_state_e;

  // dp_sel encodings: high passes data through, low inverts it
  localparam logic MODE_PASS   = 1'b1;
  localparam logic MODE_INVERT = 1'b0;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first requester at or after i_ptr wins.
module rr_pick
  import sel_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  output logic [NUM_REQ-1:0]         o_win_c,
  output logic [$clog2(NUM_REQ)-1:0] o_idx_c,
  output logic                       o_any_c
);

  localparam int unsigned PW = $clog2(NUM_REQ);
  localparam int unsigned CW = PW + 1;

  logic [CW-1:0] w_cand;

  // Walk requesters in priority order starting at the pointer, wrapping at NUM_REQ
  always_comb begin
    o_win_c = '0;
    o_idx_c = '0;
    o_any_c = 1'b0;
    w_cand  = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      w_cand = {1'b0, i_ptr} + CW'(i);
      if (w_cand >= CW'(NUM_REQ)) begin
        w_cand = w_cand - CW'(NUM_REQ);
      end
      if (!o_any_c && i_req[w_cand[PW-1:0]]) begin
        o_any_c                   = 1'b1;
        o_idx_c                   = w_cand[PW-1:0];
        o_win_c[w_cand[PW-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sel_burst_arbiter.sv
// Round-robin burst arbiter feeding a shared pass/invert select datapath.
module sel_burst_arbiter
  import sel_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_invert,
  input  logic [NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0] req_last,
  output logic [NUM_REQ-1:0] ack,
  output logic [NUM_REQ-1:0] gnt,
  output logic               dp_sel,
  output logic               dp_data,
  output logic               dp_valid,
  output logic               busy
);

  localparam int unsigned PW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  sel_arb_state_e      r_state;
  logic [PW-1:0]       r_ptr;
  logic [PW-1:0]       r_gidx;
  logic [CW-1:0]       r_cnt;
  logic [NUM_REQ-1:0]  r_gnt;
  logic                r_sel;
  logic                r_data;
  logic                r_valid;
  logic                r_busy;

  logic [NUM_REQ-1:0]  w_win;
  logic [PW-1:0]       w_idx;
  logic                w_any;
  logic [CW-1:0]       w_cnt_nxt;
  logic                w_cap;
  logic [PW-1:0]       w_ptr_nxt;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_win_c (w_win),
    .o_idx_c (w_idx),
    .o_any_c (w_any)
  );

  assign w_cnt_nxt = r_cnt + CW'(1);
  assign w_cap     = (w_cnt_nxt == CW'(MAX_BURST));
  assign w_ptr_nxt = (r_gidx == PW'(NUM_REQ - 1)) ? '0 : r_gidx + PW'(1);

  // Only the granted requester's beat is accepted, and only while bursting
  assign ack = (r_state == BURST) ? (r_gnt & req) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_gidx  <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_sel   <= MODE_PASS;
      r_data  <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state <= BURST;
            r_busy  <= 1'b1;
            r_gnt   <= w_win;
            r_gidx  <= w_idx;
            r_cnt   <= '0;
            r_sel   <= req_invert[w_idx] ? MODE_INVERT : MODE_PASS;
          end
        end
        BURST: begin
          if (!req[r_gidx]) begin
            r_state <= GAP;
            r_gnt   <= '0;
            r_ptr   <= w_ptr_nxt;
          end else begin
            r_data  <= req_data[r_gidx];
            r_valid <= 1'b1;
            r_cnt   <= w_cnt_nxt;
            if (req_last[r_gidx] || w_cap) begin
              r_state <= GAP;
              r_gnt   <= '0;
              r_ptr   <= w_ptr_nxt;
            end
          end
        end
        GAP: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  assign gnt      = r_gnt;
  assign dp_sel   = r_sel;
  assign dp_data  = r_data;
  assign dp_valid = r_valid;
  assign busy     = r_busy;

endmodule
